mem_req_arbiter: RTL and testbench

//  Upstream request stage for the DDR2 memory controller read/write port.

---
 rtl/mem_req_arbiter_if.sv | 36 +++
 rtl/mem_req_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Client-side and DDR2-controller-side signals of the two-port request arbiter.
// The slave modport is the arbiter's view; master is the clients plus controller.
interface mem_req_arbiter_if #(
    parameter int unsigned APPDATA_WIDTH    = 128,
    parameter int unsigned INPUT_ADDR_WIDTH = 31
);
    localparam int unsigned DW = APPDATA_WIDTH;
    localparam int unsigned AW = INPUT_ADDR_WIDTH;

    logic [1:0]      cli_req;
    logic [1:0]      cli_we;
    logic [2*AW-1:0] cli_addr;
    logic [4*DW-1:0] cli_wdata;
    logic [1:0]      cli_ack;
    logic [1:0]      cli_rvalid;
    logic [2*DW-1:0] cli_rdata;
    logic            cli_err;
    logic            data_wren;
    logic            data_rden;
    logic [AW-1:0]   data_addr;
    logic [2*DW-1:0] data_wr;
    logic [2*DW-1:0] data_rd;
    logic            mc_wr_rdy;
    logic            mc_rd_rdy;
    logic            mc_rd_valid;

    modport slave (
        input  cli_req, cli_we, cli_addr, cli_wdata, data_rd, mc_wr_rdy, mc_rd_rdy, mc_rd_valid,
        output cli_ack, cli_rvalid, cli_rdata, cli_err, data_wren, data_rden, data_addr, data_wr
    );

    modport master (
        output cli_req, cli_we, cli_addr, cli_wdata, data_rd, mc_wr_rdy, mc_rd_rdy, mc_rd_valid,
        input  cli_ack, cli_rvalid, cli_rdata, cli_err, data_wren, data_rden, data_addr, data_wr
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between two cache-line clients feeding one DDR2 controller port,
// one transaction at a time, with completion/read-data/timeout returned to the winner.
module mem_req_arbiter #(
    parameter int unsigned APPDATA_WIDTH    = 128,
    parameter int unsigned INPUT_ADDR_WIDTH = 31,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input logic              clk,
    input logic              rst_n,
    mem_req_arbiter_if.slave bus
);
    localparam int unsigned DW = APPDATA_WIDTH;
    localparam int unsigned AW = INPUT_ADDR_WIDTH;
    localparam int unsigned LW = 2 * DW;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {StIdle, StRdWait, StWr, StRd, StResp} state_e;

    state_e          state_q;
    logic            last_gnt_q;
    logic            id_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   wdata_q;
    logic [CW-1:0]   tmo_q;
    logic [1:0]      ack_q;
    logic [1:0]      rvalid_q;
    logic            err_q;
    logic [LW-1:0]   rdata_q;

    logic win;
    logic tmo_hit;

    function automatic logic [1:0] id_mask(input logic id);
        return {id, ~id};
    endfunction

    // On a tie the client that did not win last time goes next.
    always_comb begin
        if (bus.cli_req == 2'b11) begin
            win = ~last_gnt_q;
        end else begin
            win = bus.cli_req[1];
        end
    end

    assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            id_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tmo_q      <= '0;
            ack_q      <= '0;
            rvalid_q   <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ack_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|bus.cli_req) begin
                        id_q       <= win;
                        last_gnt_q <= win;
                        addr_q     <= win ? bus.cli_addr[2*AW-1:AW] : bus.cli_addr[AW-1:0];
                        wdata_q    <= win ? bus.cli_wdata[2*LW-1:LW] : bus.cli_wdata[LW-1:0];
                        tmo_q      <= '0;
                        state_q    <= bus.cli_we[win] ? StWr : StRdWait;
                    end
                end
                StRdWait: begin
                    if (bus.mc_rd_rdy) begin
                        tmo_q   <= '0;
                        state_q <= StRd;
                    end else if (tmo_hit) begin
                        ack_q   <= id_mask(id_q);
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StWr: begin
                    // Completion is checked first so it beats a same-cycle timeout.
                    if (bus.mc_wr_rdy) begin
                        ack_q   <= id_mask(id_q);
                        state_q <= StResp;
                    end else if (tmo_hit) begin
                        ack_q   <= id_mask(id_q);
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StRd: begin
                    if (bus.mc_rd_valid) begin
                        rdata_q  <= bus.data_rd;
                        ack_q    <= id_mask(id_q);
                        rvalid_q <= id_mask(id_q);
                        state_q  <= StResp;
                    end else if (tmo_hit) begin
                        ack_q   <= id_mask(id_q);
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.cli_ack    = ack_q;
    assign bus.cli_rvalid = rvalid_q;
    assign bus.cli_err    = err_q;
    assign bus.cli_rdata  = rdata_q;
    assign bus.data_wren  = (state_q == StWr);
    assign bus.data_rden  = (state_q == StRd);
    assign bus.data_addr  = addr_q;
    assign bus.data_wr    = wdata_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed plus randomized bench for mem_req_arbiter against a transaction-level model
// of round-robin choice, strobe lengths, timeout outcome and read-data holding.
module tb_mem_req_arbiter;
    localparam int unsigned DW = 128;
    localparam int unsigned AW = 31;
    localparam int unsigned T  = 16;
    localparam int unsigned LW = 2 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    mem_req_arbiter_if #(.APPDATA_WIDTH(DW), .INPUT_ADDR_WIDTH(AW)) bus ();

    mem_req_arbiter #(
        .APPDATA_WIDTH   (DW),
        .INPUT_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Client-side request state and the reference model.
    logic [1:0]    req;
    logic          cl_we   [2];
    logic [AW-1:0] cl_addr [2];
    logic [LW-1:0] cl_wd   [2];
    int            ref_last;
    logic [LW-1:0] ref_rdata;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rline();
        logic [LW-1:0] v;
        for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return 1 - ref_last;
        return r[1] ? 1 : 0;
    endfunction

    task automatic drive();
        bus.cli_req   = req;
        bus.cli_we    = {cl_we[1], cl_we[0]};
        bus.cli_addr  = {cl_addr[1], cl_addr[0]};
        bus.cli_wdata = {cl_wd[1], cl_wd[0]};
    endtask

    task automatic set_cli(input int c, input logic we, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd);
        cl_we[c]   = we;
        cl_addr[c] = a;
        cl_wd[c]   = wd;
        req[c]     = 1'b1;
    endtask

    // One transaction from the IDLE cycle through the IDLE cycle after RESP.
    // w: edge (after entering RD_WAIT) where mc_rd_rdy is sampled high, 0 = never.
    // d: edge (after entering WR/RD) where completion is sampled high, 0 = never.
    task automatic txn(input int w, input int d);
        int            id;
        int            n;
        int            hi;
        logic          we;
        logic          bad;
        logic          err;
        logic          active;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        logic [LW-1:0] line;
        logic [1:0]    mask;
        id       = pick(req);
        ref_last = id;
        we       = cl_we[id];
        a        = cl_addr[id];
        wd       = cl_wd[id];
        line     = rline();
        mask     = (id == 1) ? 2'b10 : 2'b01;
        drive();
        tick();
        cl_addr[id] = AW'($urandom);
        cl_wd[id]   = rline();
        drive();
        active = 1'b1;
        if (!we) begin
            n  = (w >= 1 && w < int'(T)) ? w : int'(T);
            hi = 0;
            for (int i = 1; i <= n; i++) begin
                bus.mc_rd_rdy   = (i == w);
                bus.mc_rd_valid = 1'($urandom_range(0, 1));
                bus.mc_wr_rdy   = 1'($urandom_range(0, 1));
                hi += int'(bus.data_rden) + int'(bus.data_wren);
                tick();
            end
            bus.mc_rd_rdy = 1'b0;
            check("rd_wait_strobes_low", LW'(hi), '0);
            active = (w >= 1 && w < int'(T));
        end
        err = 1'b1;
        if (active) begin
            err = (d == 0 || d > int'(T));
            n   = err ? int'(T) : d;
            hi  = 0;
            bad = 1'b0;
            for (int i = 1; i <= n; i++) begin
                if (we) begin
                    bus.mc_wr_rdy   = (i == d);
                    bus.mc_rd_valid = 1'($urandom_range(0, 1));
                    hi += int'(bus.data_wren);
                    bad |= bus.data_rden | (bus.data_wr !== wd);
                end else begin
                    bus.mc_rd_valid = (i == d);
                    bus.data_rd     = (i == d) ? line : rline();
                    bus.mc_wr_rdy   = 1'($urandom_range(0, 1));
                    hi += int'(bus.data_rden);
                    bad |= bus.data_wren;
                end
                bad |= (bus.data_addr !== a) | (bus.cli_ack !== 2'b00);
                tick();
            end
            check(we ? "wren_cycles" : "rden_cycles", LW'(hi), LW'(n));
            check("addr_data_stable", LW'(bad), '0);
        end
        bus.mc_wr_rdy   = 1'b0;
        bus.mc_rd_valid = 1'b0;
        if (!we && !err) ref_rdata = line;
        check("ack", LW'(bus.cli_ack), LW'(mask));
        check("err", LW'(bus.cli_err), LW'(err));
        check("rvalid", LW'(bus.cli_rvalid), LW'((!we && !err) ? mask : 2'b00));
        check("rdata", bus.cli_rdata, ref_rdata);
        check("resp_strobes_low", LW'({bus.data_wren, bus.data_rden}), '0);
        req[id] = 1'b0;
        drive();
        tick();
        check("idle_quiet", LW'({bus.cli_ack, bus.data_wren, bus.data_rden}), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        req       = 2'b00;
        ref_last  = 1;
        ref_rdata = '0;
        for (int c = 0; c < 2; c++) begin
            cl_we[c]   = 1'b0;
            cl_addr[c] = '0;
            cl_wd[c]   = '0;
        end
        drive();
        bus.data_rd     = '0;
        bus.mc_wr_rdy   = 1'b0;
        bus.mc_rd_rdy   = 1'b0;
        bus.mc_rd_valid = 1'b0;
        tick();
        tick();
        check("rst_ack_rvalid_err", LW'({bus.cli_ack, bus.cli_rvalid, bus.cli_err}), '0);
        check("rst_strobes", LW'({bus.data_wren, bus.data_rden}), '0);
        check("rst_rdata", bus.cli_rdata, '0);
        check("rst_data_wr", bus.data_wr, '0);
        check("rst_data_addr", LW'(bus.data_addr), '0);
        rst_n = 1'b1;
        tick();

        // Client 0 write, completion on the 8th WR edge.
        set_cli(0, 1'b1, AW'('h100), rline());
        txn(0, 8);
        // Client 1 read, controller busy for 3 cycles.
        set_cli(1, 1'b0, AW'('h200), rline());
        txn(4, 3);
        // Both clients reading back to back; grants must alternate.
        for (int k = 0; k < 4; k++) begin
            if (!req[0]) set_cli(0, 1'b0, AW'($urandom), rline());
            if (!req[1]) set_cli(1, 1'b0, AW'($urandom), rline());
            txn($urandom_range(1, 5), $urandom_range(1, 8));
        end
        // Write that never completes, then a normal one.
        set_cli(0, 1'b1, AW'($urandom), rline());
        txn(0, 0);
        set_cli(1, 1'b1, AW'($urandom), rline());
        txn(0, 5);
        // Read completion on the same edge as the timeout.
        set_cli(0, 1'b0, AW'($urandom), rline());
        txn(2, int'(T));
        // Read that never gets mc_rd_rdy: timeout from RD_WAIT, rdata untouched.
        set_cli(1, 1'b0, AW'($urandom), rline());
        txn(0, 0);
        // Stray controller strobes while idle.
        hits = 0;
        bus.mc_wr_rdy   = 1'b1;
        bus.mc_rd_valid = 1'b1;
        bus.data_rd     = rline();
        for (int i = 0; i < 4; i++) begin
            tick();
            hits += int'(bus.cli_ack != 2'b00) + int'(bus.data_wren) + int'(bus.data_rden);
        end
        bus.mc_wr_rdy   = 1'b0;
        bus.mc_rd_valid = 1'b0;
        check("stray_idle_no_ack", LW'(hits), '0);
        check("stray_idle_rdata", bus.cli_rdata, ref_rdata);

        // Randomized traffic; pending requests are held until acked.
        for (int k = 0; k < 24; k++) begin
            int w;
            int d;
            for (int c = 0; c < 2; c++) begin
                if (!req[c] && $urandom_range(0, 2) != 0) begin
                    set_cli(c, 1'($urandom_range(0, 1)), AW'($urandom), rline());
                end
            end
            if (req == 2'b00) set_cli($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                                      AW'($urandom), rline());
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            d = $urandom_range(1, T + 3);
            txn(w, d);
        end

        // Asynchronous reset while in RD.
        req = 2'b00;
        set_cli(0, 1'b0, AW'($urandom), rline());
        void'(pick(req));
        drive();
        tick();
        bus.mc_rd_rdy = 1'b1;
        tick();
        bus.mc_rd_rdy = 1'b0;
        check("rd_entered", LW'(bus.data_rden), LW'(1'b1));
        bus.mc_rd_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rden", LW'(bus.data_rden), '0);
        check("async_rst_ack", LW'({bus.cli_ack, bus.cli_rvalid, bus.cli_err}), '0);
        ref_last  = 1;
        ref_rdata = '0;
        req       = 2'b00;
        drive();
        bus.mc_rd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        hits  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            hits += int'(bus.cli_ack != 2'b00) + int'(bus.data_rden);
        end
        check("post_rst_no_ack", LW'(hits), '0);
        check("post_rst_rdata", bus.cli_rdata, '0);
        // Tie after reset: client 0 first, then client 1.
        set_cli(0, 1'b0, AW'($urandom), rline());
        set_cli(1, 1'b0, AW'($urandom), rline());
        txn(1, 2);
        txn(1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
